// File: rtl/serdac_rdbk_pkg.sv
// serdac_rdbk_pkg: shared constants and types for the DAC readback slice.
//   - VME command codes (DAC write, readback read, status clear)
//   - DAC frame geometry (word width, bit-counter width, frame length)
//   - readback FSM state encoding
//   - maj3 voter used by the triplicated primitives
package serdac_rdbk_pkg;

  localparam int         CMD_W       = 10;
  localparam logic [9:0] CMD_DAC_WR  = 10'd0;
  localparam logic [9:0] CMD_RD_DEF  = 10'd1;
  localparam logic [9:0] CMD_CLR_DEF = 10'd2;

  localparam int         DATA_W      = 16;
  localparam int         CNT_W       = 5;
  localparam logic [4:0] FRAME_LEN   = 5'd16;
  localparam logic [4:0] CNT_MAX     = 5'd31;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } rb_state_t;

  // Bitwise 2-of-3 majority vote for triplicated state.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serdac_rdbk_if.sv
// serdac_rdbk_if: VME command bus and DAC serial snoop bus for serdac_rdbk.
//   STROBE/WRITE_B/DEVICE/COMMAND : VME cycle qualifiers (from VME decode)
//   DACCS_B/DACCLK/DACOUT         : snooped DAC serial bus
//   OUTDATA/RB_VALID/FRAME_ERR    : readback data and status (from serdac_rdbk)
// modport master is the bus/VME side, modport slave is serdac_rdbk.
interface serdac_rdbk_if import serdac_rdbk_pkg::*; ();

  logic              STROBE;
  logic              WRITE_B;
  logic              DEVICE;
  logic [CMD_W-1:0]  COMMAND;
  logic              DACCS_B;
  logic              DACCLK;
  logic              DACOUT;
  logic [DATA_W-1:0] OUTDATA;
  logic              RB_VALID;
  logic              FRAME_ERR;

  modport master (
    output STROBE, WRITE_B, DEVICE, COMMAND, DACCS_B, DACCLK, DACOUT,
    input  OUTDATA, RB_VALID, FRAME_ERR
  );

  modport slave (
    input  STROBE, WRITE_B, DEVICE, COMMAND, DACCS_B, DACCLK, DACOUT,
    output OUTDATA, RB_VALID, FRAME_ERR
  );

endinterface

// File: rtl/serdac_rdbk_prims.sv
// Counter and shift-register primitives shared across the DMB codebase.
// cbnce  : binary up-counter, async reset, sync clear, count enable.
//          ports i_clk, i_rst, i_ce, i_clr -> o_q[Width]
// srnlce : shift register, async reset, sync clear, shift enable,
//          Left=1 shifts towards the MSB with i_si entering bit 0.
//          ports i_clk, i_rst, i_ce, i_clr, i_si -> o_q[Width]
// TMR=1 keeps three copies of the state and votes them bit by bit.
module cbnce import serdac_rdbk_pkg::*; #(
  parameter int Width = 5,
  parameter int TMR   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_clr,
  output logic [Width-1:0] o_q
);
  logic [Width-1:0] w_next;

  // Next count, computed from the (voted) current count
  always_comb begin
    w_next = o_q;
    if (i_clr) begin
      w_next = '0;
    end else if (i_ce) begin
      w_next = o_q + {{(Width-1){1'b0}}, 1'b1};
    end else begin
      w_next = o_q;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [Width-1:0] r_q0, r_q1, r_q2;
      // Three replicas of the count
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_q0 <= '0;
          r_q1 <= '0;
          r_q2 <= '0;
        end else begin
          r_q0 <= w_next;
          r_q1 <= w_next;
          r_q2 <= w_next;
        end
      end
      // Per-bit majority of the replicas
      always_comb begin
        o_q = '0;
        for (int b = 0; b < Width; b++) begin
          o_q[b] = maj3(r_q0[b], r_q1[b], r_q2[b]);
        end
      end
    end else begin : g_simplex
      logic [Width-1:0] r_q;
      // Single count register
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_q <= '0;
        else       r_q <= w_next;
      end
      assign o_q = r_q;
    end
  endgenerate
endmodule

module srnlce import serdac_rdbk_pkg::*; #(
  parameter int Width = 16,
  parameter int Left  = 1,
  parameter int TMR   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_clr,
  input  logic             i_si,
  output logic [Width-1:0] o_q
);
  logic [Width-1:0] w_next;

  // Next shift-register contents
  always_comb begin
    w_next = o_q;
    if (i_clr) begin
      w_next = '0;
    end else if (i_ce) begin
      if (Left != 0) w_next = {o_q[Width-2:0], i_si};
      else           w_next = {i_si, o_q[Width-1:1]};
    end else begin
      w_next = o_q;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [Width-1:0] r_q0, r_q1, r_q2;
      // Three replicas of the shift register
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_q0 <= '0;
          r_q1 <= '0;
          r_q2 <= '0;
        end else begin
          r_q0 <= w_next;
          r_q1 <= w_next;
          r_q2 <= w_next;
        end
      end
      // Per-bit majority of the replicas
      always_comb begin
        o_q = '0;
        for (int b = 0; b < Width; b++) begin
          o_q[b] = maj3(r_q0[b], r_q1[b], r_q2[b]);
        end
      end
    end else begin : g_simplex
      logic [Width-1:0] r_q;
      // Single shift register
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_q <= '0;
        else       r_q <= w_next;
      end
      assign o_q = r_q;
    end
  endgenerate
endmodule

// File: rtl/serdac_rdbk_vme.sv
// serdac_rdbk_vme: VME read/clear handshake for the DAC readback.
//   i_clk, i_rst                      : clock, async active-high reset
//   i_strobe/i_write_b/i_device/i_command : VME cycle qualifiers
//   i_hold                            : word to return on a read
//   o_outdata : hold word latched on the first read cycle, 0 otherwise
//   o_dtack   : 1 = drive DTACK_B low (from 2nd cycle of read or clear)
//   o_rd_done : one-cycle pulse on the cycle a read ends
//   o_clr     : clear cycle active (level)
module serdac_rdbk_vme import serdac_rdbk_pkg::*; #(
  parameter logic [9:0] RD_CMD  = CMD_RD_DEF,
  parameter logic [9:0] CLR_CMD = CMD_CLR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_strobe,
  input  logic              i_write_b,
  input  logic              i_device,
  input  logic [CMD_W-1:0]  i_command,
  input  logic [DATA_W-1:0] i_hold,
  output logic [DATA_W-1:0] o_outdata,
  output logic              o_dtack,
  output logic              o_rd_done,
  output logic              o_clr
);
  logic              w_rd, w_clr;
  logic              r_rd_d, r_clr_d;
  logic              r_dtack;
  logic [DATA_W-1:0] r_outdata;

  assign w_rd  = i_strobe & i_device &  i_write_b & (i_command == RD_CMD);
  assign w_clr = i_strobe & i_device & ~i_write_b & (i_command == CLR_CMD);

  // One-cycle history of the decoded cycles, to find first cycle and end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_d  <= 1'b0;
      r_clr_d <= 1'b0;
    end else begin
      r_rd_d  <= w_rd;
      r_clr_d <= w_clr;
    end
  end

  // Latch the hold word once at read start so a commit mid-read cannot tear it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_outdata <= '0;
    else if (!w_rd)   r_outdata <= '0;
    else if (!r_rd_d) r_outdata <= i_hold;
    else              r_outdata <= r_outdata;
  end

  // Acknowledge from the second cycle onwards; read and clear are exclusive
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_dtack <= 1'b0;
    else       r_dtack <= (w_rd & r_rd_d) | (w_clr & r_clr_d);
  end

  assign o_outdata = r_outdata;
  assign o_dtack   = r_dtack;
  assign o_rd_done = ~w_rd & r_rd_d;
  assign o_clr     = w_clr;
endmodule

// File: rtl/serdac_rdbk.sv
// serdac_rdbk: snoops the DAC serial bus, deserialises the DACOUT echo into
// a 16-bit word, holds the last complete word and returns it over VME.
//   MIDCLK  : system clock (same domain that generates DACCLK/DACCS_B)
//   RST     : async active-high reset
//   bus     : serdac_rdbk_if.slave (VME qualifiers, DAC bus, data/status)
//   DTACK_B : VME acknowledge, driven low or released (high-Z)
// DTACK_B is a wired bus line shared with other slaves, so it stays a plain
// tri-state port rather than an interface member.
module serdac_rdbk import serdac_rdbk_pkg::*; #(
  parameter int         TMR     = 0,
  parameter logic [9:0] RD_CMD  = CMD_RD_DEF,
  parameter logic [9:0] CLR_CMD = CMD_CLR_DEF
) (
  input  logic         MIDCLK,
  input  logic         RST,
  serdac_rdbk_if.slave bus,
  output wire          DTACK_B
);
  logic              r_cs_d, r_clk_d;
  logic              w_cs_fall, w_cs_rise, w_sclk_rise;
  rb_state_t         r_state, w_state_nxt;
  logic              w_frame_clr, w_shift_en, w_cnt_en;
  logic              w_commit_ok, w_commit_err;
  logic [CNT_W-1:0]  w_bitcnt;
  logic [DATA_W-1:0] w_shreg;
  logic [DATA_W-1:0] r_hold;
  logic              r_rb_valid, r_frame_err;
  logic [DATA_W-1:0] w_outdata;
  logic              w_dtack_en, w_rd_done, w_clr_act;

  // Delayed DAC strobes for edge detection (same clock domain, no sync)
  always_ff @(posedge MIDCLK or posedge RST) begin
    if (RST) begin
      r_cs_d  <= 1'b1;
      r_clk_d <= 1'b0;
    end else begin
      r_cs_d  <= bus.DACCS_B;
      r_clk_d <= bus.DACCLK;
    end
  end

  assign w_cs_fall   =  r_cs_d  & ~bus.DACCS_B;
  assign w_cs_rise   = ~r_cs_d  &  bus.DACCS_B;
  assign w_sclk_rise = ~r_clk_d &  bus.DACCLK;

  // FSM state register
  always_ff @(posedge MIDCLK or posedge RST) begin
    if (RST) r_state <= ST_WAIT_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; WAIT_IDLE discards any frame already running at reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (bus.DACCS_B) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_WAIT_IDLE;
      end
      ST_IDLE: begin
        if (w_cs_fall) w_state_nxt = ST_ACTIVE;
        else           w_state_nxt = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (w_cs_rise) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_WAIT_IDLE;
    endcase
  end

  // FSM outputs: frame clear, shift/count strobes and the commit decision
  always_comb begin
    w_frame_clr  = 1'b0;
    w_shift_en   = 1'b0;
    w_cnt_en     = 1'b0;
    w_commit_ok  = 1'b0;
    w_commit_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_frame_clr = 1'b1;
        else           w_frame_clr = 1'b0;
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          if (w_bitcnt == FRAME_LEN) w_commit_ok  = 1'b1;
          else                       w_commit_err = 1'b1;
        end else if (w_sclk_rise && !bus.DACCS_B) begin
          w_shift_en = 1'b1;
          // Count saturates so an over-long frame can never wrap back to 16
          w_cnt_en   = (w_bitcnt != CNT_MAX);
        end else begin
          w_shift_en = 1'b0;
        end
      end
      default: w_frame_clr = 1'b0;
    endcase
  end

  cbnce #(.Width(CNT_W), .TMR(TMR)) u_bitcnt (
    .i_clk (MIDCLK),
    .i_rst (RST),
    .i_ce  (w_cnt_en),
    .i_clr (w_frame_clr),
    .o_q   (w_bitcnt)
  );

  srnlce #(.Width(DATA_W), .Left(1), .TMR(TMR)) u_shreg (
    .i_clk (MIDCLK),
    .i_rst (RST),
    .i_ce  (w_shift_en),
    .i_clr (w_frame_clr),
    .i_si  (bus.DACOUT),
    .o_q   (w_shreg)
  );

  // Hold register and status; a good commit outranks read-end and clear
  always_ff @(posedge MIDCLK or posedge RST) begin
    if (RST) begin
      r_hold      <= '0;
      r_rb_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_commit_ok) r_hold <= w_shreg;
      if (w_commit_ok)                  r_rb_valid <= 1'b1;
      else if (w_rd_done || w_clr_act)  r_rb_valid <= 1'b0;
      if (w_commit_ok)       r_frame_err <= 1'b0;
      else if (w_commit_err) r_frame_err <= 1'b1;
      else if (w_clr_act)    r_frame_err <= 1'b0;
    end
  end

  serdac_rdbk_vme #(.RD_CMD(RD_CMD), .CLR_CMD(CLR_CMD)) u_vme (
    .i_clk     (MIDCLK),
    .i_rst     (RST),
    .i_strobe  (bus.STROBE),
    .i_write_b (bus.WRITE_B),
    .i_device  (bus.DEVICE),
    .i_command (bus.COMMAND),
    .i_hold    (r_hold),
    .o_outdata (w_outdata),
    .o_dtack   (w_dtack_en),
    .o_rd_done (w_rd_done),
    .o_clr     (w_clr_act)
  );

  assign bus.OUTDATA   = w_outdata;
  assign bus.RB_VALID  = r_rb_valid;
  assign bus.FRAME_ERR = r_frame_err;
  assign DTACK_B       = w_dtack_en ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_serdac_rdbk.sv
// Bench for serdac_rdbk. Stimulus pushes expected results into queues; a
// monitor watching the bus pops and compares on each read, clear and frame
// end. DTACK_B carries a pull-up, so a released line reads back as 1.
module tb_serdac_rdbk;

  typedef struct packed {
    logic [15:0] data;
    logic        rbv;
  } rd_exp_t;

  typedef struct packed {
    logic rbv;
    logic ferr;
  } st_exp_t;

  logic MIDCLK;
  logic RST;
  wire  w_dtack_b;
  pullup (w_dtack_b);

  serdac_rdbk_if bus ();

  serdac_rdbk #(.TMR(0), .RD_CMD(10'd1), .CLR_CMD(10'd2)) dut (
    .MIDCLK  (MIDCLK),
    .RST     (RST),
    .bus     (bus),
    .DTACK_B (w_dtack_b)
  );

  rd_exp_t q_rd[$];
  st_exp_t q_clr[$];
  st_exp_t q_fr[$];

  int   n_tests;
  int   n_fail;
  logic done;
  logic p_rd, pp_rd, p_clr, pp_clr, p_cs, pp_cs, rst_checked;

  initial begin
    MIDCLK = 1'b0;
    forever #5 MIDCLK = ~MIDCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge MIDCLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.DACOUT = b;
    bus.DACCLK = 1'b1;
    tick();
    bus.DACCLK = 1'b0;
    tick();
  endtask

  task automatic frame(input logic [31:0] pat, input int nbits, input logic drop_rd);
    bus.DACCS_B = 1'b0;
    tick();
    tick();
    for (int i = 0; i < nbits; i++) send_bit(pat[nbits-1-i]);
    bus.DACCS_B = 1'b1;
    if (drop_rd) bus.STROBE = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_rd();
    bus.DEVICE  = 1'b1;
    bus.WRITE_B = 1'b1;
    bus.COMMAND = 10'd1;
    bus.STROBE  = 1'b1;
  endtask

  task automatic bus_idle();
    bus.STROBE  = 1'b0;
    bus.DEVICE  = 1'b0;
    bus.WRITE_B = 1'b1;
    bus.COMMAND = 10'd0;
  endtask

  task automatic do_read(input int n);
    start_rd();
    repeat (n) tick();
    bus_idle();
    tick();
    tick();
  endtask

  task automatic do_clear(input int n);
    bus.DEVICE  = 1'b1;
    bus.WRITE_B = 1'b0;
    bus.COMMAND = 10'd2;
    bus.STROBE  = 1'b1;
    repeat (n) tick();
    bus_idle();
    tick();
    tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus with hand-computed expectations
  initial begin : stim
    done        = 1'b0;
    RST         = 1'b1;
    bus_idle();
    bus.DACCS_B = 1'b1;
    bus.DACCLK  = 1'b0;
    bus.DACOUT  = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    tick();

    // Good frame, then read it back
    q_fr.push_back('{1'b1, 1'b0});
    frame(32'h0000A5C3, 16, 1'b0);
    q_rd.push_back('{16'hA5C3, 1'b0});
    do_read(4);

    // Short and long frames: error, hold kept
    q_fr.push_back('{1'b0, 1'b1});
    frame(32'h00001234, 15, 1'b0);
    q_fr.push_back('{1'b0, 1'b1});
    frame(32'h000FFFFF, 20, 1'b0);
    q_rd.push_back('{16'hA5C3, 1'b0});
    do_read(3);

    // Good frame, short frame keeps RB_VALID, clear drops both flags
    q_fr.push_back('{1'b1, 1'b0});
    frame(32'h0000A5C3, 16, 1'b0);
    q_fr.push_back('{1'b1, 1'b1});
    frame(32'h00005555, 15, 1'b0);
    q_clr.push_back('{1'b0, 1'b0});
    do_clear(3);
    q_rd.push_back('{16'hA5C3, 1'b0});
    do_read(3);

    // Reset in the middle of a frame: no commit, hold back to 0
    q_fr.push_back('{1'b1, 1'b0});
    frame(32'h00005A5A, 16, 1'b0);
    q_fr.push_back('{1'b0, 1'b0});
    bus.DACCS_B = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    bus.DACCS_B = 1'b1;
    tick();
    tick();
    q_rd.push_back('{16'h0000, 1'b0});
    do_read(2);
    q_fr.push_back('{1'b1, 1'b0});
    frame(32'h00001234, 16, 1'b0);
    q_rd.push_back('{16'h1234, 1'b0});
    do_read(3);

    // Commit on the same cycle the read strobe drops
    q_rd.push_back('{16'h1234, 1'b1});
    q_fr.push_back('{1'b1, 1'b0});
    start_rd();
    tick();
    tick();
    frame(32'h0000BEEF, 16, 1'b1);
    bus_idle();
    tick();
    q_rd.push_back('{16'hBEEF, 1'b0});
    do_read(3);

    repeat (3) tick();
    done = 1'b1;
  end

  // Monitor: decodes bus activity one cycle behind and checks the DUT
  initial begin : monitor
    rd_exp_t cur_rd;
    st_exp_t st;
    logic    cur_rd_v, cur_clr_v;
    n_tests     = 0;
    n_fail      = 0;
    p_rd        = 1'b0;
    pp_rd       = 1'b0;
    p_clr       = 1'b0;
    pp_clr      = 1'b0;
    p_cs        = 1'b1;
    pp_cs       = 1'b1;
    rst_checked = 1'b0;
    cur_rd      = '{16'h0000, 1'b0};
    forever begin
      @(negedge MIDCLK);
      if (done) begin
        chk("rd_queue_empty",  16'(q_rd.size()),  16'd0);
        chk("clr_queue_empty", 16'(q_clr.size()), 16'd0);
        chk("fr_queue_empty",  16'(q_fr.size()),  16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (RST && !rst_checked) begin
        chk("rst_outdata",   bus.OUTDATA,            16'h0000);
        chk("rst_rb_valid",  16'(bus.RB_VALID),      16'd0);
        chk("rst_frame_err", 16'(bus.FRAME_ERR),     16'd0);
        chk("rst_dtack",     16'(w_dtack_b),         16'd1);
        rst_checked = 1'b1;
      end
      // Read cycle
      if (p_rd && !pp_rd) begin
        if (q_rd.size() == 0) begin
          chk("rd_unexpected", 16'd1, 16'd0);
          cur_rd = '{16'h0000, 1'b0};
        end else begin
          cur_rd = q_rd.pop_front();
        end
        chk("rd_first_data",  bus.OUTDATA,    cur_rd.data);
        chk("rd_first_dtack", 16'(w_dtack_b), 16'd1);
      end else if (p_rd && pp_rd) begin
        chk("rd_hold_data",  bus.OUTDATA,    cur_rd.data);
        chk("rd_hold_dtack", 16'(w_dtack_b), 16'd0);
      end else if (!p_rd && pp_rd) begin
        chk("rd_end_data",     bus.OUTDATA,       16'h0000);
        chk("rd_end_dtack",    16'(w_dtack_b),    16'd1);
        chk("rd_end_rb_valid", 16'(bus.RB_VALID), 16'(cur_rd.rbv));
      end
      // Clear cycle
      if (p_clr && !pp_clr) begin
        if (q_clr.size() == 0) begin
          chk("clr_unexpected", 16'd1, 16'd0);
          st = '{1'b0, 1'b0};
        end else begin
          st = q_clr.pop_front();
        end
        chk("clr_rb_valid",    16'(bus.RB_VALID),  16'(st.rbv));
        chk("clr_frame_err",   16'(bus.FRAME_ERR), 16'(st.ferr));
        chk("clr_first_dtack", 16'(w_dtack_b),     16'd1);
      end else if (p_clr && pp_clr) begin
        chk("clr_hold_dtack", 16'(w_dtack_b), 16'd0);
      end else if (!p_clr && pp_clr) begin
        chk("clr_end_dtack", 16'(w_dtack_b), 16'd1);
      end
      // Frame end (chip select rising)
      if (p_cs && !pp_cs) begin
        if (q_fr.size() == 0) begin
          chk("fr_unexpected", 16'd1, 16'd0);
          st = '{1'b0, 1'b0};
        end else begin
          st = q_fr.pop_front();
        end
        chk("fr_rb_valid",  16'(bus.RB_VALID),  16'(st.rbv));
        chk("fr_frame_err", 16'(bus.FRAME_ERR), 16'(st.ferr));
      end
      cur_rd_v  = bus.STROBE & bus.DEVICE &  bus.WRITE_B & (bus.COMMAND == 10'd1);
      cur_clr_v = bus.STROBE & bus.DEVICE & ~bus.WRITE_B & (bus.COMMAND == 10'd2);
      pp_rd  = p_rd;
      p_rd   = cur_rd_v & ~RST;
      pp_clr = p_clr;
      p_clr  = cur_clr_v & ~RST;
      pp_cs  = p_cs;
      p_cs   = bus.DACCS_B;
    end
  end

endmodule
